stego_engine: RTL and testbench
===============================

STEGO_ENGINE -- requirements
Module: stego_engine

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, width of the size inputs and counters.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports start  in  1 (run request, level), sgp_mode  in  1 (0 embed, 1 extract) and ps_enb  in  1 (pixel-stream enable).
REQ-005 SHALL have ports pixel_size, secret_size, output_size  in  REG_WIDTH  job lengths in pixels, characters and output beats.
REQ-006 SHALL have ports s_pix_tdata  in  8, s_pix_tvalid  in  1, s_pix_tready  out  1  pixel stream.
REQ-007 SHALL have ports s_sec_tdata  in  8 (bits[5:0] used), s_sec_tvalid  in  1, s_sec_tready  out  1  secret-character stream.
REQ-008 SHALL have ports m_out_tdata  out  8, m_out_tvalid  out  1, m_out_tready  in  1, m_out_tlast  out  1  result stream.
REQ-009 SHALL have port out_finish  out  1  job complete, level.

Function
REQ-010 SHALL implement FSM IDLE, EMBED, EXTRACT, DONE.
REQ-011 IDLE: on start=1, SHALL latch all three sizes, clear counters and go to EMBED (sgp_mode=0) or EXTRACT (sgp_mode=1); sgp_mode is latched with the sizes.
REQ-012 IDLE: if the latched output_size is 0, SHALL go directly to DONE with no stream traffic.
REQ-013 Handshakes: a transfer occurs only when valid and ready are both high; tvalid/tdata SHALL NOT change while valid and not ready.
REQ-014 s_pix_tready SHALL be 1 only in EMBED/EXTRACT, with ps_enb=1, pix_cnt < pixel_size, and the output register empty or draining in the same cycle.
REQ-015 EMBED: s_sec_tready SHALL be 1 when no character is held and sec_cnt < secret_size; a pixel SHALL NOT be accepted unless a character is held.
REQ-016 EMBED: pixel k of a group (k=0..5) SHALL be output as {pixel[7:1], char[k]}, LSB first; character released after k=5.
REQ-017 EMBED latency: accepted pixel SHALL appear on m_out one cycle later.
REQ-018 EXTRACT: s_sec_tready SHALL be 0; pixel k LSB SHALL be stored in char bit k; after k=5 the byte {2'b00, char[5:0]} SHALL be valid on m_out the next cycle.
REQ-019 m_out_tlast SHALL be 1 exactly on the beat where out_cnt+1 == output_size.
REQ-020 The handshake of the tlast beat SHALL move FSM to DONE next cycle.
REQ-021 DONE: out_finish=1; SHALL return to IDLE when start=0; start held high keeps DONE (no restart).
REQ-022 Secret bytes beyond secret_size and pixels beyond pixel_size SHALL NOT be accepted.
REQ-023 Counters are REG_WIDTH bits, unsigned; no wrap within a job.
REQ-024 ps_enb=0 mid-job SHALL stall pixel intake only; held output and counters retained.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, clear all counters, the held character, and the output register, at any time including mid-job.
REQ-026 Reset values: s_pix_tready=0, s_sec_tready=0, m_out_tvalid=0, m_out_tdata=0, m_out_tlast=0, out_finish=0.

Configuration
REQ-027 Macro STEGO_KEY_EN SHALL, when defined, add port key  in  6, XOR the character with key before embedding and the assembled character with key after extraction; when undefined, no key port exists and data passes unscrambled.

Structure
REQ-028 Package stego_pkg SHALL hold the FSM state typedef and constants BITS_PER_CHAR=6, PIXEL_W=8.
REQ-029 One sub-module stego_out_reg SHALL implement the single-entry valid/ready output register with tlast.

Verification
REQ-030 Embed, secret_size=1, pixel_size=6, output_size=6, char 0x2D, pixels 0xFF x6 -> outputs FF,FE,FF,FF,FE,FF; tlast on 6th; out_finish next cycle.
REQ-031 Extract, pixel_size=6, output_size=1, pixels LSBs 1,0,1,1,0,1 -> one byte 0x2D with tlast; s_sec_tready stays 0.
REQ-032 Embed 2 chars with m_out_tready toggling 1/0 every cycle -> 12 beats, no loss/duplication, data stable while stalled.
REQ-033 output_size=0 with start=1 -> DONE after one cycle, out_finish=1, no tvalid; start=0 -> IDLE.
REQ-034 reset=0 asserted after 3 embed beats -> all outputs at reset values that cycle; fresh job afterwards matches REQ-030.
REQ-035 STEGO_KEY_EN defined, key=0x3F, embed char 0x2D -> LSBs carry 0x12; extract round-trip with same key returns 0x2D.

Source files
------------

// File: rtl/stego_pkg.sv
// Shared definitions for the steganography engine: FSM state type,
// character/pixel geometry and the LSB-substitution helper.
package stego_pkg;

    localparam int BITS_PER_CHAR = 6;
    localparam int PIXEL_W       = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMBED   = 2'd1,
        EXTRACT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Replace the pixel LSB with one secret bit.
    function automatic logic [PIXEL_W-1:0] embed_pixel(
        input logic [PIXEL_W-1:0] pix,
        input logic               bit_val
    );
        return {pix[PIXEL_W-1:1], bit_val};
    endfunction

endpackage

// File: rtl/stego_out_reg.sv
// Single-entry valid/ready output register carrying data plus a last flag.
// A new beat may be loaded when the register is empty or is being drained
// in the same cycle, so back-to-back beats flow at full rate.
module stego_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         last,
    output logic         can_load
);

    assign can_load = !valid || ready;

    // Hold the beat until it is taken; data/last never move while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stego_engine.sv
// LSB steganography engine. EMBED writes one secret-character bit (LSB
// first) into the LSB of each pixel; EXTRACT rebuilds 6-bit characters from
// six pixel LSBs. Optional macro STEGO_KEY_EN adds a 6-bit XOR key port.
// Handshake rule for every stream: a beat transfers on a rising edge where
// valid and ready are both high; a source keeps valid/data stable until then.
module stego_engine
    import stego_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef STEGO_KEY_EN
    input  logic [BITS_PER_CHAR-1:0] key,
`endif
    input  logic                     start,
    input  logic                     sgp_mode,
    input  logic                     ps_enb,
    input  logic [REG_WIDTH-1:0]     pixel_size,
    input  logic [REG_WIDTH-1:0]     secret_size,
    input  logic [REG_WIDTH-1:0]     output_size,
    input  logic [PIXEL_W-1:0]       s_pix_tdata,
    input  logic                     s_pix_tvalid,
    output logic                     s_pix_tready,
    input  logic [PIXEL_W-1:0]       s_sec_tdata,
    input  logic                     s_sec_tvalid,
    output logic                     s_sec_tready,
    output logic [PIXEL_W-1:0]       m_out_tdata,
    output logic                     m_out_tvalid,
    input  logic                     m_out_tready,
    output logic                     m_out_tlast,
    output logic                     out_finish,
    output state_t                   dbg_state
);

    localparam logic [REG_WIDTH-1:0] ONE      = REG_WIDTH'(1);
    localparam logic [2:0]           LAST_BIT = 3'(BITS_PER_CHAR - 1);

    state_t                   state, state_nxt;
    logic [REG_WIDTH-1:0]     pixel_size_r, secret_size_r, output_size_r;
    logic [REG_WIDTH-1:0]     pix_cnt, sec_cnt, beat_cnt;
    logic [2:0]               bit_idx;
    logic [BITS_PER_CHAR-1:0] char_reg;
    logic                     char_held;
    logic [BITS_PER_CHAR-1:0] key_v;
    logic [BITS_PER_CHAR-1:0] assembled;
    logic                     busy, char_last;
    logic                     pix_fire, sec_fire;
    logic                     out_load, out_last_in, out_can_load;
    logic [PIXEL_W-1:0]       out_data_in;
    logic                     unused_sec_bits;

`ifdef STEGO_KEY_EN
    assign key_v = key;
`else
    assign key_v = '0;
`endif

    // Only the low six bits of a secret byte carry a character.
    assign unused_sec_bits = ^s_sec_tdata[PIXEL_W-1:BITS_PER_CHAR];

    assign busy      = (state == EMBED) || (state == EXTRACT);
    assign char_last = (bit_idx == LAST_BIT);

    // Pixel intake also stops once every output beat has been produced, so
    // nothing is left stranded in the output register after the last beat.
    assign s_pix_tready = busy && ps_enb
                          && (pix_cnt < pixel_size_r)
                          && (beat_cnt < output_size_r)
                          && out_can_load
                          && ((state == EXTRACT) || char_held);
    assign s_sec_tready = (state == EMBED) && !char_held && (sec_cnt < secret_size_r);
    assign pix_fire     = s_pix_tvalid && s_pix_tready;
    assign sec_fire     = s_sec_tvalid && s_sec_tready;
    assign out_finish   = (state == DONE);
    assign dbg_state    = state;

    // Build the beat to load: embedded pixel, or the completed character.
    always_comb begin
        assembled   = {s_pix_tdata[0], char_reg[BITS_PER_CHAR-2:0]} ^ key_v;
        out_load    = pix_fire && ((state == EMBED) || char_last);
        out_last_in = ((beat_cnt + ONE) == output_size_r);
        if (state == EMBED)
            out_data_in = embed_pixel(s_pix_tdata, char_reg[bit_idx]);
        else
            out_data_in = {{(PIXEL_W-BITS_PER_CHAR){1'b0}}, assembled};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state: the tlast handshake ends the job; DONE waits for start low.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (output_size == '0) state_nxt = DONE;
                    else if (sgp_mode)     state_nxt = EXTRACT;
                    else                   state_nxt = EMBED;
                end
            end
            EMBED, EXTRACT: begin
                if (m_out_tvalid && m_out_tready && m_out_tlast) state_nxt = DONE;
            end
            DONE: begin
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job sizes, counters and the character being embedded or assembled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_size_r  <= '0;
            secret_size_r <= '0;
            output_size_r <= '0;
            pix_cnt       <= '0;
            sec_cnt       <= '0;
            beat_cnt      <= '0;
            bit_idx       <= '0;
            char_reg      <= '0;
            char_held     <= 1'b0;
        end else if (state == IDLE && start) begin
            pixel_size_r  <= pixel_size;
            secret_size_r <= secret_size;
            output_size_r <= output_size;
            pix_cnt       <= '0;
            sec_cnt       <= '0;
            beat_cnt      <= '0;
            bit_idx       <= '0;
            char_reg      <= '0;
            char_held     <= 1'b0;
        end else begin
            if (sec_fire) begin
                char_reg  <= s_sec_tdata[BITS_PER_CHAR-1:0] ^ key_v;
                char_held <= 1'b1;
                bit_idx   <= '0;
                sec_cnt   <= sec_cnt + ONE;
            end
            if (pix_fire) begin
                pix_cnt <= pix_cnt + ONE;
                if (state == EXTRACT) char_reg[bit_idx] <= s_pix_tdata[0];
                if (char_last) begin
                    bit_idx <= '0;
                    if (state == EMBED) char_held <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end
            if (out_load) beat_cnt <= beat_cnt + ONE;
        end
    end

    stego_out_reg #(
        .W(PIXEL_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (out_load),
        .load_data (out_data_in),
        .load_last (out_last_in),
        .ready     (m_out_tready),
        .valid     (m_out_tvalid),
        .data      (m_out_tdata),
        .last      (m_out_tlast),
        .can_load  (out_can_load)
    );

endmodule

// File: tb/tb_stego_engine.sv
// Self-checking bench for stego_engine: directed cases plus random jobs
// checked against a behavioural embed/extract model.
module tb_stego_engine;
    import stego_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, sgp_mode = 1'b0, ps_enb = 1'b1;
    logic [31:0] pixel_size = '0, secret_size = '0, output_size = '0;
    logic [7:0]  s_pix_tdata = '0, s_sec_tdata = '0;
    logic        s_pix_tvalid = 1'b0, s_sec_tvalid = 1'b0, m_out_tready = 1'b0;
    logic        s_pix_tready, s_sec_tready, m_out_tvalid, m_out_tlast, out_finish;
    logic [7:0]  m_out_tdata;
    logic [5:0]  key = '0;
    state_t      dbg_state;

    always #5 clk = ~clk;

    stego_engine #(.REG_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef STEGO_KEY_EN
        .key          (key),
`endif
        .start        (start),
        .sgp_mode     (sgp_mode),
        .ps_enb       (ps_enb),
        .pixel_size   (pixel_size),
        .secret_size  (secret_size),
        .output_size  (output_size),
        .s_pix_tdata  (s_pix_tdata),
        .s_pix_tvalid (s_pix_tvalid),
        .s_pix_tready (s_pix_tready),
        .s_sec_tdata  (s_sec_tdata),
        .s_sec_tvalid (s_sec_tvalid),
        .s_sec_tready (s_sec_tready),
        .m_out_tdata  (m_out_tdata),
        .m_out_tvalid (m_out_tvalid),
        .m_out_tready (m_out_tready),
        .m_out_tlast  (m_out_tlast),
        .out_finish   (out_finish),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] pix_q[$];
    logic [7:0] sec_q[$];
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int got_beats, pix_acc, sec_acc;
    bit finished;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: LSB substitution / LSB gathering, from the queues.
    task automatic build_model(input bit mode, input int nout);
        logic [5:0] c;
        logic [7:0] p;
        exp_q.delete();
        for (int i = 0; i < nout; i++) begin
            if (!mode) begin
                c = sec_q[i / 6][5:0] ^ key;
                p = pix_q[i];
                exp_q.push_back({p[7:1], c[i % 6]});
            end else begin
                c = '0;
                for (int k = 0; k < 6; k++) begin
                    p = pix_q[6 * i + k];
                    c[k] = p[0];
                end
                exp_q.push_back({2'b00, c ^ key});
            end
        end
    endtask

    // ---------------- driver / monitor ----------------
    // rdy_mode: 0 always ready, 1 toggling, 2 random (also random ps_enb).
    // stop_beats>0 returns early after that many output beats.
    task automatic run_job(input bit mode, input int psz, input int ssz, input int nout,
                           input int rdy_mode, input int stop_beats, input int budget,
                           input bit use_model);
        int pix_idx = 0, sec_idx = 0;
        bit prev_stall = 0, prev_last = 0;
        logic [7:0] prev_data = '0;
        bit pix_fire, sec_fire, last_fire;
        got_beats = 0; pix_acc = 0; sec_acc = 0; finished = 0;
        if (use_model) build_model(mode, nout);
        @(negedge clk);
        sgp_mode = mode; pixel_size = psz; secret_size = ssz; output_size = nout;
        start = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (!s_pix_tvalid && pix_idx < pix_q.size() && $urandom_range(0, 3) != 0) begin
                s_pix_tvalid = 1'b1; s_pix_tdata = pix_q[pix_idx];
            end
            if (!s_sec_tvalid && sec_idx < sec_q.size() && $urandom_range(0, 3) != 0) begin
                s_sec_tvalid = 1'b1; s_sec_tdata = sec_q[sec_idx];
            end
            case (rdy_mode)
                0:       m_out_tready = 1'b1;
                1:       m_out_tready = (cyc % 2 == 0);
                default: m_out_tready = 1'($urandom_range(0, 1));
            endcase
            ps_enb = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (mode) check("extract_sec_ready", 32'(s_sec_tready), 0);
            if (!ps_enb) check("ps_enb_stall", 32'(s_pix_tready), 0);
            if (pix_acc >= psz) check("pix_limit", 32'(s_pix_tready), 0);
            if (prev_stall)
                check("stall_hold", {22'd0, m_out_tvalid, m_out_tlast, m_out_tdata},
                      {22'd0, 1'b1, prev_last, prev_data});
            last_fire = 0;
            if (m_out_tvalid && m_out_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    check("out_data", 32'(m_out_tdata), 32'(exp_q.pop_front()));
                end
                check("out_last", 32'(m_out_tlast), 32'(got_beats + 1 == nout));
                got_beats++;
                last_fire = m_out_tlast;
            end
            prev_stall = m_out_tvalid && !m_out_tready;
            prev_data  = m_out_tdata;
            prev_last  = m_out_tlast;
            pix_fire   = s_pix_tvalid && s_pix_tready;
            sec_fire   = s_sec_tvalid && s_sec_tready;
            @(negedge clk);
            if (pix_fire) begin pix_idx++; pix_acc++; s_pix_tvalid = 1'b0; end
            if (sec_fire) begin sec_idx++; sec_acc++; s_sec_tvalid = 1'b0; end
            if (last_fire) begin
                #1;
                check("finish_after_last", {30'd0, out_finish, 1'b0} | 32'(dbg_state == DONE), 32'h3);
                finished = 1;
                break;
            end
            if (stop_beats != 0 && got_beats >= stop_beats) break;
        end
        ps_enb = 1'b1;
    endtask

    // DONE holds while start is high, then returns to IDLE once start drops.
    task automatic end_job();
        s_pix_tvalid = 1'b0; s_sec_tvalid = 1'b0;
        @(negedge clk); #1;
        check("done_hold", 32'(out_finish), 1);
        check("done_no_valid", 32'(m_out_tvalid), 0);
        start = 1'b0;
        @(negedge clk); #1;
        check("back_idle_finish", 32'(out_finish), 0);
        check("back_idle_state", 32'(dbg_state), 32'(IDLE));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_rdy"}, 32'(s_pix_tready), 0);
        check({tag, "_sec_rdy"}, 32'(s_sec_tready), 0);
        check({tag, "_valid"},   32'(m_out_tvalid), 0);
        check({tag, "_data"},    32'(m_out_tdata), 0);
        check({tag, "_last"},    32'(m_out_tlast), 0);
        check({tag, "_finish"},  32'(out_finish), 0);
        check({tag, "_state"},   32'(dbg_state), 32'(IDLE));
    endtask

    task automatic load_req030();
        pix_q.delete(); sec_q.delete(); exp_q.delete();
        for (int i = 0; i < 6; i++) pix_q.push_back(8'hFF);
        sec_q.push_back(8'h2D); sec_q.push_back(8'h15);
        exp_q = '{8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'hFF};
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] pat;
        logic [7:0] r;
        int nch, nout, extra;
        bit mode;

        // Reset state
        #2;
        check_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Embed one character into six white pixels; second char must be refused
        load_req030();
        run_job(0, 6, 1, 6, 0, 0, 200, 0);
        check("req030_finished", 32'(finished), 1);
        check("req030_beats", got_beats, 6);
        check("req030_sec_acc", sec_acc, 1);
        end_job();

        // Extract one character from LSB pattern 1,0,1,1,0,1
        pix_q.delete(); sec_q.delete(); exp_q.delete();
        pat = 6'b101101;
        for (int k = 0; k < 6; k++) begin
            r = 8'($urandom); r[0] = pat[k]; pix_q.push_back(r);
        end
        sec_q.push_back(8'h3F);
        exp_q.push_back(8'h2D);
        run_job(1, 6, 0, 1, 0, 0, 200, 0);
        check("req031_finished", 32'(finished), 1);
        check("req031_sec_acc", sec_acc, 0);
        end_job();

        // Two characters with a toggling sink
        pix_q.delete(); sec_q.delete();
        for (int i = 0; i < 12; i++) pix_q.push_back(8'($urandom));
        for (int i = 0; i < 2; i++) sec_q.push_back(8'($urandom));
        run_job(0, 12, 2, 12, 1, 0, 300, 1);
        check("req032_finished", 32'(finished), 1);
        check("req032_beats", got_beats, 12);
        check("req032_pix_acc", pix_acc, 12);
        end_job();

        // Zero-length job goes straight to DONE
        @(negedge clk);
        sgp_mode = 1'b0; pixel_size = 6; secret_size = 1; output_size = 0;
        s_pix_tvalid = 1'b1; s_pix_tdata = 8'hA5; start = 1'b1;
        #1;
        check("zero_idle_pix_rdy", 32'(s_pix_tready), 0);
        @(negedge clk); #1;
        check("zero_done_finish", 32'(out_finish), 1);
        check("zero_done_valid", 32'(m_out_tvalid), 0);
        check("zero_done_pix_rdy", 32'(s_pix_tready), 0);
        end_job();

        // Reset mid-job after three beats, then rerun the first job
        load_req030();
        run_job(0, 6, 1, 6, 0, 3, 200, 0);
        check("req034_beats_before", got_beats, 3);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        start = 1'b0; s_pix_tvalid = 1'b0; s_sec_tvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        load_req030();
        run_job(0, 6, 1, 6, 0, 0, 200, 0);
        check("req034_rerun_finished", 32'(finished), 1);
        check("req034_rerun_beats", got_beats, 6);
        end_job();

        // Pixel budget smaller than the output length: intake stops at pixel_size
        pix_q.delete(); sec_q.delete();
        for (int i = 0; i < 10; i++) pix_q.push_back(8'($urandom));
        sec_q.push_back(8'($urandom));
        run_job(0, 3, 1, 6, 0, 0, 40, 1);
        check("pixlim_not_finished", 32'(finished), 0);
        check("pixlim_pix_acc", pix_acc, 3);
        check("pixlim_beats", got_beats, 3);
        reset = 1'b0; start = 1'b0; s_pix_tvalid = 1'b0; s_sec_tvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Random jobs against the model
        for (int j = 0; j < 6; j++) begin
            mode = 1'($urandom_range(0, 1));
            nch = $urandom_range(1, 4);
            extra = $urandom_range(0, 3);
`ifdef STEGO_KEY_EN
            key = 6'($urandom);
`endif
            pix_q.delete(); sec_q.delete();
            nout = mode ? nch : $urandom_range(1, 6 * nch);
            for (int i = 0; i < (mode ? 6 * nout : nout) + extra; i++) pix_q.push_back(8'($urandom));
            for (int i = 0; i < nch + 1; i++) sec_q.push_back(8'($urandom));
            run_job(mode, pix_q.size(), mode ? 0 : nch, nout, 2, 0, 3000, 1);
            check("rand_finished", 32'(finished), 1);
            check("rand_beats", got_beats, nout);
            check("rand_pix_acc", pix_acc, mode ? 6 * nout : nout);
            check("rand_sec_bound", 32'(sec_acc <= (mode ? 0 : nch)), 1);
            end_job();
        end

`ifdef STEGO_KEY_EN
        // Keyed embed: 0x2D ^ 0x3F = 0x12 in the LSBs
        key = 6'h3F;
        pix_q.delete(); sec_q.delete(); exp_q.delete();
        for (int i = 0; i < 6; i++) pix_q.push_back(8'hFF);
        sec_q.push_back(8'h2D);
        exp_q = '{8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'hFF, 8'hFE};
        run_job(0, 6, 1, 6, 0, 0, 200, 0);
        check("key_embed_finished", 32'(finished), 1);
        end_job();
        // Keyed extract of those pixels returns the original character
        pix_q = '{8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'hFF, 8'hFE};
        sec_q.delete(); exp_q.delete();
        exp_q.push_back(8'h2D);
        run_job(1, 6, 0, 1, 0, 0, 200, 0);
        check("key_extract_finished", 32'(finished), 1);
        end_job();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
